// File: rtl/fa_intf_pkg.sv
// Shared constants and result type for the registered full-adder endpoint.
package fa_intf_pkg;

  localparam int unsigned FA_MAX_WIDTH = 64;

  // Widest result the block can produce. Narrower instances use the low s bits.
  typedef struct packed {
    logic                    cout;
    logic [FA_MAX_WIDTH-1:0] s;
  } fa_result_t;

endpackage

// File: rtl/fa_bit_cell.sv
// Single-bit combinational full adder; one link of the ripple-carry chain.
module fa_bit_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & cin) | (b & cin) | (a & b);

endmodule

// File: rtl/fa_intf_core.sv
// Registered ripple-carry adder with a valid qualifier and one cycle of latency.
// Optional signed-overflow output is enabled with FA_INTF_CORE_OVF_EN.
module fa_intf_core
  import fa_intf_pkg::*;
#(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] s,
  output logic             cout,
`ifdef FA_INTF_CORE_OVF_EN
  output logic             ovf,
`endif
  output logic             out_valid
);

  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum;

  assign carry[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_chain
    fa_bit_cell u_cell (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (carry[i]),
      .s    (sum[i]),
      .cout (carry[i+1])
    );
  end

  logic [WIDTH-1:0] s_q;
  logic             cout_q;
  logic             valid_q;

  // Operands are only sampled when valid, so X/Z on idle cycles never reaches state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_q     <= '0;
      cout_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= in_valid;
      if (in_valid) begin
        s_q    <= sum;
        cout_q <= carry[WIDTH];
      end
    end
  end

  assign s         = s_q;
  assign cout      = cout_q;
  assign out_valid = valid_q;

`ifdef FA_INTF_CORE_OVF_EN
  logic ovf_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (in_valid) begin
      ovf_q <= carry[WIDTH] ^ carry[WIDTH-1];
    end
  end

  assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_fa_intf_core.sv
// Directed bench for fa_intf_core at WIDTH=1 and WIDTH=8.
module tb_fa_intf_core;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       iv1 = 1'b0;
  logic [0:0] a1  = '0;
  logic [0:0] b1  = '0;
  logic       c1  = 1'b0;
  logic [0:0] s1;
  logic       co1;
  logic       ov1;

  logic       iv8 = 1'b0;
  logic [7:0] a8  = '0;
  logic [7:0] b8  = '0;
  logic       c8  = 1'b0;
  logic [7:0] s8;
  logic       co8;
  logic       ov8;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  fa_intf_core #(.WIDTH(1)) dut1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (iv1),
    .a         (a1),
    .b         (b1),
    .cin       (c1),
    .s         (s1),
    .cout      (co1),
`ifdef FA_INTF_CORE_OVF_EN
    .ovf       (),
`endif
    .out_valid (ov1)
  );

  logic ovf8;

  fa_intf_core #(.WIDTH(8)) dut8 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (iv8),
    .a         (a8),
    .b         (b8),
    .cin       (c8),
    .s         (s8),
    .cout      (co8),
`ifdef FA_INTF_CORE_OVF_EN
    .ovf       (ovf8),
`endif
    .out_valid (ov8)
  );

`ifndef FA_INTF_CORE_OVF_EN
  assign ovf8 = 1'b0;
`endif

  task automatic test_reset();
    #2;
    vectors++;
    if ({ov1, co1, s1} !== 3'b000) begin
      $display("FAIL reset_w1 got v/co/s=%b want 000", {ov1, co1, s1});
      miscompares++;
    end
    vectors++;
    if ({ov8, co8, s8} !== 10'h000) begin
      $display("FAIL reset_w8 got v/co/s=%b want 0", {ov8, co8, s8});
      miscompares++;
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single();
    @(negedge clk);
    iv1 = 1'b1; a1 = 1'b1; b1 = 1'b0; c1 = 1'b0;
    @(posedge clk); #1;
    iv1 = 1'b0;
    vectors++;
    if ({ov1, co1, s1} !== 3'b101) begin
      $display("FAIL single_w1 got v/co/s=%b want 101", {ov1, co1, s1});
      miscompares++;
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] vin [3];
    logic [1:0] vexp [3];
    vin[0] = 3'b000; vexp[0] = 2'b00;
    vin[1] = 3'b111; vexp[1] = 2'b11;
    vin[2] = 3'b101; vexp[2] = 2'b10;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      iv1 = 1'b1; {a1, b1, c1} = vin[i];
      @(posedge clk); #1;
      vectors++;
      if ({ov1, co1, s1} !== {1'b1, vexp[i]}) begin
        $display("FAIL b2b_%0d got v/co/s=%b want %b", i, {ov1, co1, s1}, {1'b1, vexp[i]});
        miscompares++;
      end
    end
    iv1 = 1'b0;
  endtask

  task automatic test_width8();
    @(negedge clk);
    iv8 = 1'b1; a8 = 8'hFF; b8 = 8'h01; c8 = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if ({ov8, co8, s8} !== {2'b11, 8'h00}) begin
      $display("FAIL w8_ff01 got v=%b co=%b s=%h want v=1 co=1 s=00", ov8, co8, s8);
      miscompares++;
    end
`ifdef FA_INTF_CORE_OVF_EN
    vectors++;
    if (ovf8 !== 1'b0) begin
      $display("FAIL w8_ff01_ovf got %b want 0", ovf8);
      miscompares++;
    end
`endif
    a8 = 8'h7F; b8 = 8'h00; c8 = 1'b1;
    @(posedge clk); #1;
    iv8 = 1'b0;
    vectors++;
    if ({ov8, co8, s8} !== {2'b10, 8'h80}) begin
      $display("FAIL w8_7f00c got v=%b co=%b s=%h want v=1 co=0 s=80", ov8, co8, s8);
      miscompares++;
    end
`ifdef FA_INTF_CORE_OVF_EN
    vectors++;
    if (ovf8 !== 1'b1) begin
      $display("FAIL w8_7f00c_ovf got %b want 1", ovf8);
      miscompares++;
    end
`endif
  endtask

  task automatic test_hold();
    @(negedge clk);
    iv8 = 1'b1; a8 = 8'h12; b8 = 8'h34; c8 = 1'b1;
    iv1 = 1'b1; a1 = 1'b1; b1 = 1'b1; c1 = 1'b0;
    @(posedge clk); #1;
    iv8 = 1'b0; a8 = 8'hAA; b8 = 8'hFF; c8 = 1'b1;
    iv1 = 1'b0; a1 = 1'bx; b1 = 1'bz; c1 = 1'bx;
    vectors++;
    if ({ov8, co8, s8} !== {2'b10, 8'h47}) begin
      $display("FAIL hold_load got v=%b co=%b s=%h want v=1 co=0 s=47", ov8, co8, s8);
      miscompares++;
    end
    @(posedge clk); #1;
    vectors++;
    if ({ov8, co8, s8} !== {2'b00, 8'h47}) begin
      $display("FAIL hold_w8 got v=%b co=%b s=%h want v=0 co=0 s=47", ov8, co8, s8);
      miscompares++;
    end
    vectors++;
    if ({ov1, co1, s1} !== 3'b010) begin
      $display("FAIL hold_w1_x got v/co/s=%b want 010", {ov1, co1, s1});
      miscompares++;
    end
    a1 = 1'b0; b1 = 1'b0; c1 = 1'b0;
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    iv1 = 1'b1; a1 = 1'b1; b1 = 1'b0; c1 = 1'b1;
    @(posedge clk); #1;
    iv1 = 1'b0;
    vectors++;
    if ({ov1, co1, s1} !== 3'b110) begin
      $display("FAIL pre_rst got v/co/s=%b want 110", {ov1, co1, s1});
      miscompares++;
    end
    #1 rst = 1'b1;
    #1;
    vectors++;
    if ({ov1, co1, s1} !== 3'b000) begin
      $display("FAIL async_rst got v/co/s=%b want 000", {ov1, co1, s1});
      miscompares++;
    end
    @(negedge clk);
    rst = 1'b0;
    iv1 = 1'b1; a1 = 1'b1; b1 = 1'b1; c1 = 1'b0;
    @(posedge clk); #1;
    iv1 = 1'b0;
    vectors++;
    if ({ov1, co1, s1} !== 3'b110) begin
      $display("FAIL post_rst got v/co/s=%b want 110", {ov1, co1, s1});
      miscompares++;
    end
  endtask

  task automatic test_exhaustive();
    logic [2:0] v;
    logic [1:0] want;
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      want = 2'(v[2]) + 2'(v[1]) + 2'(v[0]);
      iv1 = 1'b1; a1 = v[2]; b1 = v[1]; c1 = v[0];
      @(posedge clk); #1;
      vectors++;
      if ({ov1, co1, s1} !== {1'b1, want}) begin
        $display("FAIL exh_%0d got v/co/s=%b want %b", i, {ov1, co1, s1}, {1'b1, want});
        miscompares++;
      end
    end
    iv1 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_width8();
    test_hold();
    test_async_reset();
    test_exhaustive();
    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
